// File: rtl/ram_io_responder.sv
// ram_io_responder: byte-wide bus responder for the RISC-V core.
// Serves a 2^RAM_ADDR_WIDTH byte RAM below 0x20000, reads of the hole at
// 0x20000-0x2FFFF as zero, and the I/O window at 0x30000.
// The I/O window holds an RX FIFO, a TX FIFO, a cycle counter and the
// program-stop register.
// Build option: define RAM_IO_CYCLE_COUNTER_EN to include the cycle counter
// and its snapshot. Without it, reads of 0x30004-0x30007 return zero.
module ram_io_responder #(
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int RX_DEPTH       = 16,
   parameter int TX_DEPTH       = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [31:0] mem_a_in,
   input  logic        mem_wr_in,
   input  logic [7:0]  mem_dout_in,
   output logic [7:0]  mem_din_out,
   output logic        cpu_rdy_out,
   input  logic        rx_valid_in,
   input  logic [7:0]  rx_data_in,
   output logic        rx_ready_out,
   output logic        tx_valid_out,
   output logic [7:0]  tx_data_out,
   input  logic        tx_ready_in,
   output logic        program_done_out,
   output logic        tx_overflow_out
);

   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int TX_AW = $clog2(TX_DEPTH);

   localparam logic [RX_AW:0]   RX_FULL    = (RX_AW+1)'(RX_DEPTH);
   localparam logic [RX_AW:0]   RX_CNT_ONE = (RX_AW+1)'(1);
   localparam logic [RX_AW-1:0] RX_PTR_ONE = RX_AW'(1);
   localparam logic [TX_AW:0]   TX_FULL    = (TX_AW+1)'(TX_DEPTH);
   localparam logic [TX_AW:0]   TX_CNT_ONE = (TX_AW+1)'(1);
   localparam logic [TX_AW:0]   TX_CNT_TWO = (TX_AW+1)'(2);
   localparam logic [TX_AW-1:0] TX_PTR_ONE = TX_AW'(1);
   localparam logic [18:0]      RAM_BYTES  = 19'(1) << RAM_ADDR_WIDTH;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [17:0] addr;
   logic        unusedAddrBits;
   logic        ioSel, ramSel, ioData, ioStop;
   logic        rdEn, wrEn;

   logic [7:0]       ramMem [2**RAM_ADDR_WIDTH];
   logic [7:0]       ramRdata_q;
   logic             rdFromRam_q;
   logic [7:0]       ioRdata_q, ioRdata_d;

   logic [7:0]       rxMem [RX_DEPTH];
   logic [RX_AW-1:0] rxWr_q, rxRd_q;
   logic [RX_AW:0]   rxCount_q;
   logic             rxPush, rxPop, rxNotEmpty;

   logic [7:0]       txMem [TX_DEPTH];
   logic [TX_AW-1:0] txWr_q, txRd_q;
   logic [TX_AW:0]   txCount_q, txFree;
   logic             txPushReq, txPush, txPop, txFull;
   logic [7:0]       txPushData;
   logic             txOverflow_q;

`ifdef RAM_IO_CYCLE_COUNTER_EN
   logic [31:0]      cycleCount_q, snapshot_q;
   logic             ioCnt;
`endif

   // Address decode: only bits [17:0] matter; the RAM never overlaps the I/O window.
   assign addr           = mem_a_in[17:0];
   assign unusedAddrBits = ^mem_a_in[31:18];
   assign ioSel          = (addr[17:16] == 2'b11);
   assign ramSel         = !ioSel && ({1'b0, addr} < RAM_BYTES);
   assign ioData         = ioSel && (addr[2:0] == 3'b000);
   assign ioStop         = ioSel && (addr[2:0] == 3'b100);
`ifdef RAM_IO_CYCLE_COUNTER_EN
   assign ioCnt          = ioSel && addr[2];
`endif

   // A bus cycle only takes effect while the core is allowed to proceed.
   assign rdEn = cpu_rdy_out && !mem_wr_in;
   assign wrEn = cpu_rdy_out &&  mem_wr_in;

   // Ready depends only on state and TX level, so a write accepted in the last
   // ready cycle always has room in the TX FIFO.
   assign txFree      = TX_FULL - txCount_q;
   assign cpu_rdy_out = (state_q == RUN) && (txFree >= TX_CNT_TWO);

   // RX FIFO control: the host pushes while not full, the CPU pops via 0x30000.
   assign rxNotEmpty   = (rxCount_q != '0);
   assign rx_ready_out = (rxCount_q != RX_FULL);
   assign rxPush       = rx_valid_in && rx_ready_out;
   assign rxPop        = rdEn && ioData && rxNotEmpty;

   // TX FIFO control: nonzero data writes and the stop marker (0x00) push;
   // a pop in the same cycle makes room even when the FIFO is full.
   assign txFull       = (txCount_q == TX_FULL);
   assign txPushReq    = wrEn && ((ioData && (mem_dout_in != 8'h00)) || ioStop);
   assign txPushData   = ioStop ? 8'h00 : mem_dout_in;
   assign txPop        = tx_valid_out && tx_ready_in;
   assign txPush       = txPushReq && (!txFull || txPop);
   assign tx_valid_out = (txCount_q != '0);
   assign tx_data_out  = tx_valid_out ? txMem[txRd_q] : 8'h00;

   assign program_done_out = (state_q == HALT);
   assign tx_overflow_out  = txOverflow_q;
   assign mem_din_out      = rdFromRam_q ? ramRdata_q : ioRdata_q;

   // Byte RAM with a registered read port; contents survive reset.
   always_ff @(posedge clk_in) begin
      if (wrEn && ramSel) begin
         ramMem[addr[RAM_ADDR_WIDTH-1:0]] <= mem_dout_in;
      end
      if (rdEn && ramSel) begin
         ramRdata_q <= ramMem[addr[RAM_ADDR_WIDTH-1:0]];
      end
   end

   // Read data for everything that is not RAM: RX head, counter bytes, or zero.
   always_comb begin
      ioRdata_d = 8'h00;
      if (ioData && rxNotEmpty) begin
         ioRdata_d = rxMem[rxRd_q];
      end
`ifdef RAM_IO_CYCLE_COUNTER_EN
      if (ioCnt) begin
         case (addr[1:0])
            2'd0:    ioRdata_d = cycleCount_q[7:0];
            2'd1:    ioRdata_d = snapshot_q[15:8];
            2'd2:    ioRdata_d = snapshot_q[23:16];
            default: ioRdata_d = snapshot_q[31:24];
         endcase
      end
`endif
   end

   // Read result register: remembers the source so the value holds until the next read.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rdFromRam_q <= 1'b0;
         ioRdata_q   <= 8'h00;
      end else if (rdEn) begin
         rdFromRam_q <= ramSel;
         if (!ramSel) begin
            ioRdata_q <= ioRdata_d;
         end
      end
   end

   // RX FIFO storage; entries are only meaningful below the count.
   always_ff @(posedge clk_in) begin
      if (rxPush) begin
         rxMem[rxWr_q] <= rx_data_in;
      end
   end

   // RX FIFO pointers and occupancy.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rxWr_q    <= '0;
         rxRd_q    <= '0;
         rxCount_q <= '0;
      end else begin
         if (rxPush) begin
            rxWr_q <= rxWr_q + RX_PTR_ONE;
         end
         if (rxPop) begin
            rxRd_q <= rxRd_q + RX_PTR_ONE;
         end
         if (rxPush && !rxPop) begin
            rxCount_q <= rxCount_q + RX_CNT_ONE;
         end else if (rxPop && !rxPush) begin
            rxCount_q <= rxCount_q - RX_CNT_ONE;
         end
      end
   end

   // TX FIFO storage; the head is shown directly on tx_data_out.
   always_ff @(posedge clk_in) begin
      if (txPush) begin
         txMem[txWr_q] <= txPushData;
      end
   end

   // TX FIFO pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         txWr_q       <= '0;
         txRd_q       <= '0;
         txCount_q    <= '0;
         txOverflow_q <= 1'b0;
      end else begin
         if (txPush) begin
            txWr_q <= txWr_q + TX_PTR_ONE;
         end
         if (txPop) begin
            txRd_q <= txRd_q + TX_PTR_ONE;
         end
         if (txPush && !txPop) begin
            txCount_q <= txCount_q + TX_CNT_ONE;
         end else if (txPop && !txPush) begin
            txCount_q <= txCount_q - TX_CNT_ONE;
         end
         if (txPushReq && !txPush) begin
            txOverflow_q <= 1'b1;
         end
      end
   end

`ifdef RAM_IO_CYCLE_COUNTER_EN
   // Free-running cycle counter, frozen once the program stops; the snapshot is
   // taken on a byte-0 read so the following byte reads see one coherent value.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cycleCount_q <= 32'h0;
         snapshot_q   <= 32'h0;
      end else begin
         if (state_q == RUN) begin
            cycleCount_q <= cycleCount_q + 32'd1;
         end
         if (rdEn && ioCnt && (addr[1:0] == 2'd0)) begin
            snapshot_q <= cycleCount_q;
         end
      end
   end
`endif

   // Program state register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a stop write starts draining; HALT is reached once TX is empty.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (wrEn && ioStop) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if ((txCount_q == '0) && !tx_valid_out) begin
               state_d = HALT;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder: self-checking bench for ram_io_responder.
// CPU reads and TX bytes are predicted into queues when the stimulus is
// driven and compared when the DUT produces them.
module tb_ram_io_responder;

   localparam logic [31:0] IDLE_ADDR = 32'h0002_0000;
   localparam logic [31:0] IO_DATA   = 32'h0003_0000;
   localparam logic [31:0] IO_CNT    = 32'h0003_0004;
`ifdef RAM_IO_CYCLE_COUNTER_EN
   localparam bit COUNTER_ON = 1'b1;
`else
   localparam bit COUNTER_ON = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic [31:0] mem_a_in;
   logic        mem_wr_in;
   logic [7:0]  mem_dout_in;
   logic [7:0]  mem_din_out;
   logic        cpu_rdy_out;
   logic        rx_valid_in;
   logic [7:0]  rx_data_in;
   logic        rx_ready_out;
   logic        tx_valid_out;
   logic [7:0]  tx_data_out;
   logic        tx_ready_in;
   logic        program_done_out;
   logic        tx_overflow_out;

   int          testsRun    = 0;
   int          testsFailed = 0;
   logic [7:0]  readQ[$];
   logic [7:0]  txQ[$];
   logic [31:0] edgeCount;
   logic [31:0] snap;

   ram_io_responder #(
      .RAM_ADDR_WIDTH(17),
      .RX_DEPTH(16),
      .TX_DEPTH(16)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .mem_a_in(mem_a_in),
      .mem_wr_in(mem_wr_in),
      .mem_dout_in(mem_dout_in),
      .mem_din_out(mem_din_out),
      .cpu_rdy_out(cpu_rdy_out),
      .rx_valid_in(rx_valid_in),
      .rx_data_in(rx_data_in),
      .rx_ready_out(rx_ready_out),
      .tx_valid_out(tx_valid_out),
      .tx_data_out(tx_data_out),
      .tx_ready_in(tx_ready_in),
      .program_done_out(program_done_out),
      .tx_overflow_out(tx_overflow_out)
   );

   // 100 MHz clock.
   always #5 clk_in = ~clk_in;

   // Number of clock edges since reset release, i.e. the expected live counter value.
   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         edgeCount <= 32'h0;
      end else begin
         edgeCount <= edgeCount + 32'd1;
      end
   end

   // TX monitor: a handshake seen mid-cycle completes at the next rising edge.
   always @(negedge clk_in) begin
      if (rst_in && tx_valid_out && tx_ready_in) begin
         if (txQ.size() != 0) begin
            checkOutput("txByte", {24'h0, tx_data_out}, {24'h0, txQ.pop_front()});
         end else begin
            checkOutput("txUnexpected", {24'h0, tx_data_out}, 32'h100);
         end
      end
   end

   // Global time limit so the run always ends.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [7:0] data);
      mem_a_in    = addr;
      mem_wr_in   = wr;
      mem_dout_in = data;
      tick();
      mem_a_in    = IDLE_ADDR;
      mem_wr_in   = 1'b0;
      mem_dout_in = 8'h00;
   endtask

   task automatic readAndCheck(input string tag, input logic [31:0] addr, input logic [7:0] expected);
      readQ.push_back(expected);
      applyStimulus(addr, 1'b0, 8'h00);
      checkOutput(tag, {24'h0, mem_din_out}, {24'h0, readQ.pop_front()});
   endtask

   task automatic txWrite(input logic [7:0] data);
      if (data != 8'h00) begin
         txQ.push_back(data);
      end
      applyStimulus(IO_DATA, 1'b1, data);
   endtask

   task automatic waitReady(input string tag);
      int n = 0;
      while (!cpu_rdy_out && n < 200) begin
         tick();
         n++;
      end
      checkOutput(tag, {31'h0, cpu_rdy_out}, 32'h1);
   endtask

   task automatic waitTxDrain(input string tag);
      int n = 0;
      while (txQ.size() != 0 && n < 500) begin
         tick();
         n++;
      end
      checkOutput(tag, txQ.size(), 32'h0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_din"},     {24'h0, mem_din_out},      32'h0);
      checkOutput({tag, "_rdy"},     {31'h0, cpu_rdy_out},      32'h1);
      checkOutput({tag, "_rxRdy"},   {31'h0, rx_ready_out},     32'h1);
      checkOutput({tag, "_txValid"}, {31'h0, tx_valid_out},     32'h0);
      checkOutput({tag, "_txData"},  {24'h0, tx_data_out},      32'h0);
      checkOutput({tag, "_done"},    {31'h0, program_done_out}, 32'h0);
      checkOutput({tag, "_ovf"},     {31'h0, tx_overflow_out},  32'h0);
   endtask

   task automatic counterRead(input string tag);
      snap = edgeCount;
      for (int k = 0; k < 4; k++) begin
         readAndCheck($sformatf("%s_b%0d", tag, k), IO_CNT + 32'(k),
                      COUNTER_ON ? snap[8*k +: 8] : 8'h00);
      end
   endtask

   initial begin
      mem_a_in    = IDLE_ADDR;
      mem_wr_in   = 1'b0;
      mem_dout_in = 8'h00;
      rx_valid_in = 1'b0;
      rx_data_in  = 8'h00;
      tx_ready_in = 1'b0;
      rst_in      = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      checkResetOutputs("reset");
      rst_in = 1'b1;

      // Cycle counter: value of the byte-0 read cycle, held coherent for bytes 1..3.
      while (edgeCount < 32'd100) tick();
      counterRead("cnt100");
      while (edgeCount < 32'h2FF) tick();
      counterRead("cnt2FF");

      // RAM, hole and aliasing.
      applyStimulus(32'h0000_0010, 1'b1, 8'hA5);
      readAndCheck("ramRd", 32'h0000_0010, 8'hA5);
      readAndCheck("holeRd", 32'h0002_0004, 8'h00);
      applyStimulus(32'h0001_FFFF, 1'b1, 8'h5A);
      readAndCheck("ramTop", 32'h0001_FFFF, 8'h5A);
      applyStimulus(32'h0002_0010, 1'b1, 8'h77);
      readAndCheck("holeNoAlias", 32'h0000_0010, 8'hA5);

      // RX FIFO basic traffic.
      rx_valid_in = 1'b1;
      rx_data_in  = 8'h41;
      tick();
      checkOutput("rxReady1", {31'h0, rx_ready_out}, 32'h1);
      rx_data_in  = 8'h42;
      tick();
      rx_valid_in = 1'b0;
      checkOutput("rxReady2", {31'h0, rx_ready_out}, 32'h1);
      readAndCheck("rxPop0", IO_DATA, 8'h41);
      readAndCheck("rxPop1", IO_DATA, 8'h42);
      readAndCheck("rxPopEmpty", IO_DATA, 8'h00);

      // RX FIFO full: extra bytes refused, including during a pop of a full FIFO.
      rx_valid_in = 1'b1;
      for (int i = 0; i < 16; i++) begin
         rx_data_in = 8'h80 + 8'(i);
         tick();
      end
      rx_data_in = 8'hEE;
      tick();
      checkOutput("rxFull", {31'h0, rx_ready_out}, 32'h0);
      readAndCheck("rxFullPop", IO_DATA, 8'h80);
      rx_valid_in = 1'b0;
      for (int i = 1; i < 16; i++) begin
         readAndCheck($sformatf("rxFill%0d", i), IO_DATA, 8'h80 + 8'(i));
      end
      readAndCheck("rxFillEmpty", IO_DATA, 8'h00);
      checkOutput("rxReadyAgain", {31'h0, rx_ready_out}, 32'h1);

      // TX backpressure with the sink stalled.
      tx_ready_in = 1'b0;
      for (int i = 0; i < 15; i++) begin
         waitReady($sformatf("txRdy%0d", i));
         txWrite(8'h31 + 8'(i));
      end
      checkOutput("txBackpressure", {31'h0, cpu_rdy_out}, 32'h0);
      checkOutput("txFwftValid", {31'h0, tx_valid_out}, 32'h1);
      checkOutput("txFwftData", {24'h0, tx_data_out}, 32'h31);
      applyStimulus(IO_DATA, 1'b1, 8'h55);
      checkOutput("txOverflowHeld", {31'h0, tx_overflow_out}, 32'h0);
      tx_ready_in = 1'b1;
      waitReady("txRdyZero");
      txWrite(8'h00);
      waitReady("txRdyTail");
      txWrite(8'h7E);
      waitTxDrain("txDrain");
      tick();
      checkOutput("txIdle", {31'h0, tx_valid_out}, 32'h0);
      checkOutput("txOverflowEnd", {31'h0, tx_overflow_out}, 32'h0);

      // Stop with three bytes pending: drain, then halt.
      tx_ready_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         waitReady($sformatf("stopRdy%0d", i));
         txWrite(8'h61 + 8'(i));
      end
      waitReady("stopRdyW");
      txQ.push_back(8'h00);
      applyStimulus(IO_CNT, 1'b1, 8'h99);
      checkOutput("drainRdy", {31'h0, cpu_rdy_out}, 32'h0);
      checkOutput("drainDone", {31'h0, program_done_out}, 32'h0);
      tick();
      checkOutput("drainRdyHold", {31'h0, cpu_rdy_out}, 32'h0);
      tx_ready_in = 1'b1;
      waitTxDrain("drainTx");
      tick();
      checkOutput("haltDone", {31'h0, program_done_out}, 32'h1);
      checkOutput("haltRdy", {31'h0, cpu_rdy_out}, 32'h0);
      checkOutput("haltTxValid", {31'h0, tx_valid_out}, 32'h0);

      // Leave HALT, enter DRAIN again, then reset asynchronously mid-cycle.
      tx_ready_in = 1'b0;
      rst_in = 1'b0;
      tick();
      rst_in = 1'b1;
      readAndCheck("ramAfterReset", 32'h0000_0010, 8'hA5);
      applyStimulus(32'h0000_1234, 1'b1, 8'hC3);
      readAndCheck("ramC3", 32'h0000_1234, 8'hC3);
      waitReady("rstRdy0");
      txWrite(8'h71);
      waitReady("rstRdy1");
      txQ.push_back(8'h00);
      applyStimulus(IO_CNT, 1'b1, 8'h00);
      checkOutput("rstDrainRdy", {31'h0, cpu_rdy_out}, 32'h0);
      checkOutput("rstDrainValid", {31'h0, tx_valid_out}, 32'h1);
      #3;
      rst_in = 1'b0;
      txQ.delete();
      #1;
      checkResetOutputs("midReset");
      tick();
      rst_in = 1'b1;
      readAndCheck("ramKeep", 32'h0000_1234, 8'hC3);
      readAndCheck("rxEmptyAfterReset", IO_DATA, 8'h00);
      checkOutput("txEmptyAfterReset", {31'h0, tx_valid_out}, 32'h0);

      checkOutput("txQueueLeft", txQ.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/ram_io_responder.md
# ram_io_responder

Bus responder for the RISC-V CPU's byte-wide memory port. It answers the core's address/data/write bus with a 128 KB byte RAM and the memory-mapped I/O window at 0x30000. The I/O window provides an RX input FIFO, a TX output FIFO, a free-running cycle counter and a program-stop handshake. It sits between the CPU core and the board's UART/host-interface logic, and drives the core's ready input.

## Interface
- `RAM_ADDR_WIDTH`, 17: byte-address width of the internal RAM (2^17 = 128 KB).
- `RX_DEPTH`, 16: RX FIFO entries; power of two, ≥ 4.
- `TX_DEPTH`, 16: TX FIFO entries; power of two, ≥ 4.
- `clk_in` in 1: single clock; every register is on its rising edge.
- `rst_in` in 1: asynchronous, active-low reset.
- `mem_a_in` in 32: CPU address; only [17:0] is decoded.
- `mem_wr_in` in 1: 1 = write, 0 = read.
- `mem_dout_in` in 8: CPU write data.
- `mem_din_out` out 8: read data to the CPU, registered.
- `cpu_rdy_out` out 1: drives the core's `rdy_in`.
- `rx_valid_in` in 1 / `rx_data_in` in 8 / `rx_ready_out` out 1: host byte input, valid/ready.
- `tx_valid_out` out 1 / `tx_data_out` out 8 / `tx_ready_in` in 1: byte output, valid/ready.
- `program_done_out` out 1: sticky; program has stopped and TX has drained.
- `tx_overflow_out` out 1: sticky; a TX byte was dropped.

## Operation
- Address decode:
  - RAM when `mem_a_in[17:16] != 2'b11` and address < 0x20000.
  - I/O when `mem_a_in[17:16] == 2'b11`; select on [2:0].
  - 0x20000–0x2FFFF: reads return 0x00, writes are ignored.
- A bus cycle counts only while `cpu_rdy_out`=1. When it is 0, inputs are ignored and no side effects occur.
- RAM:
  - Read returns the byte at the address presented.
  - Write stores `mem_dout_in`.
  - RAM contents are not reset.
- Read 0x30000:
  - RX FIFO non-empty: pop the head and return it.
  - RX FIFO empty: return 0x00, no pop.
- Write 0x30000:
  - Byte ≠ 0x00: push to TX FIFO.
  - Byte = 0x00: ignored.
- Read 0x30004+k (k = 0..3): returns byte k of the cycle-counter snapshot.
  - Reading k=0 also loads the snapshot from the live counter, so a 4-byte sequential read is coherent.
- Write 0x30004 (any data): push 0x00 to TX and enter DRAIN.
- Cycle counter: 32-bit, increments every clock in RUN, wraps 0xFFFFFFFF→0, freezes in DRAIN/HALT.
- FSM states:
  - RUN: normal operation. A write to 0x30004 → DRAIN.
  - DRAIN: `cpu_rdy_out`=0. When TX FIFO is empty and `tx_valid_out`=0 → HALT.
  - HALT: `program_done_out`=1, `cpu_rdy_out`=0. Left only by reset.
- TX backpressure:
  - In RUN, `cpu_rdy_out` = (TX free entries ≥ 2). A write accepted in the last ready cycle therefore always fits.
  - A push onto a full FIFO drops the byte and sets `tx_overflow_out`.
- RX: `rx_ready_out` = RX FIFO not full. A simultaneous push and pop on a full FIFO is not accepted; `rx_ready_out` already reads 0.
- TX FIFO handles a simultaneous push and pop at any level, full included; the count is unchanged.

## Timing
- Read latency: address at edge N → `mem_din_out` valid after edge N+1. The value holds until the next accepted read.
- Write: one cycle; the effect is visible to a read at the next address cycle, including read-after-write to the same byte.
- I/O side effects (pop, push, snapshot) happen at the edge ending the accepted cycle.
- FIFO traffic:
  - RX byte accepted at edge N is readable by a CPU read presented at N+1.
  - TX output is first-word-fall-through; a byte pushed at edge N shows `tx_valid_out`=1 from N+1.
- `cpu_rdy_out` is combinational from FIFO level and state registers; no path from `mem_*` inputs.
- Reset values:
  - `mem_din_out`=0x00, `cpu_rdy_out`=1, `rx_ready_out`=1.
  - `tx_valid_out`=0, `tx_data_out`=0x00.
  - `program_done_out`=0, `tx_overflow_out`=0.
  - Counter 0, snapshot 0, FSM=RUN, FIFOs empty.
- Reset asserted mid-operation clears all of the above immediately; RAM is untouched.

## Configuration
- `RAM_IO_CYCLE_COUNTER_EN` defined: counter and snapshot are built as described.
- `RAM_IO_CYCLE_COUNTER_EN` undefined: no counter or snapshot registers; reads of 0x30004–0x30007 return 0x00. The stop-write behaviour is unchanged.

## Test plan
- Write 0xA5 to 0x00010, then read 0x00010 → `mem_din_out`=0xA5 one cycle after the read address; read 0x20004 → 0x00.
- Push RX 0x41, 0x42; read 0x30000 three times → 0x41, 0x42, 0x00; `rx_ready_out` stays 1.
- Hold `tx_ready_in`=0; write 0x30000 with 0x31..0x3F → `cpu_rdy_out` falls once free entries < 2, and `tx_overflow_out` stays 0. Release → bytes emerge in order; a 0x00 write produces no TX byte.
- With the counter enabled, 100 cycles after reset read 0x30004..0x30007 → little-endian value equal to the cycle of the k=0 read, unchanged across the four reads.
- Write 0x30004 with 3 bytes pending in TX → DRAIN, `cpu_rdy_out`=0; TX emits 3 bytes then 0x00; `program_done_out`=1 the cycle after the last pop; counter frozen.
- Assert `rst_in`=0 during DRAIN → all outputs return to reset values asynchronously; RAM data written earlier still reads back.
